// File: rtl/pe_rr_arbiter.sv
// Registered N-way request encoder with fixed-priority or round-robin arbitration.
// Each winner is held as binary index + one-hot grant under a valid/ready handshake.
module pe_rr_arbiter #(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mode,
    input  logic [N-1:0] in,
    output logic [W-1:0] out,
    output logic [N-1:0] grant,
    output logic         valid,
    input  logic         ready
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;

    logic [W-1:0] out_q;
    logic [N-1:0] grant_q;
    logic [W-1:0] ptr_q;
    logic         rr_q;

    logic         any_c;
    logic         hs_c;
    logic         load_c;
    logic         clear_c;
    logic [W-1:0] ptr_next_c;
    logic [W-1:0] start_c;
    logic [W-1:0] fixed_win_c;
    logic [W-1:0] rr_win_c;
    logic [W-1:0] win_c;
    logic [N-1:0] onehot_c;

    assign any_c = |in;
    assign hs_c  = (state_q == HOLD) && ready;

    // Pointer wraps at N-1, so non-power-of-two N never produces an illegal index.
    assign ptr_next_c = (out_q == LAST_IDX) ? '0 : out_q + W'(1);

    // A winner loaded on a handshake edge already sees the advanced pointer.
    assign start_c = (hs_c && rr_q) ? ptr_next_c : ptr_q;

    always_comb begin : fixed_pick
        fixed_win_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (in[i]) fixed_win_c = W'(i);
        end
    end

    always_comb begin : rr_pick
        logic [W-1:0] cand;
        logic         found;
        rr_win_c = start_c;
        cand     = start_c;
        found    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && in[cand]) begin
                rr_win_c = cand;
                found    = 1'b1;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + W'(1);
        end
    end

    assign win_c = mode ? rr_win_c : fixed_win_c;

    always_comb begin : onehot_gen
        onehot_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            onehot_c[i] = (win_c == W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_c) state_d = HOLD;
            HOLD:    if (ready && !any_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : fsm_outputs
        load_c  = 1'b0;
        clear_c = 1'b0;
        case (state_q)
            IDLE: load_c = any_c;
            HOLD: begin
                load_c  = ready && any_c;
                clear_c = ready && !any_c;
            end
            default: ;
        endcase
    end

    // Result registers; out keeps its last value when the grant is retired.
    always_ff @(posedge clk or negedge rst_n) begin : result_reg
        if (!rst_n) begin
            out_q   <= '0;
            grant_q <= '0;
            rr_q    <= 1'b0;
        end else if (load_c) begin
            out_q   <= win_c;
            grant_q <= onehot_c;
            rr_q    <= mode;
        end else if (clear_c) begin
            grant_q <= '0;
        end
    end

    // Pointer advances only on an accepted round-robin grant.
    always_ff @(posedge clk or negedge rst_n) begin : ptr_reg
        if (!rst_n)            ptr_q <= '0;
        else if (hs_c && rr_q) ptr_q <= ptr_next_c;
    end

    assign out   = out_q;
    assign grant = grant_q;
    assign valid = (state_q == HOLD);

    a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        valid |-> (grant == (N'(1) << out)));
    a_grant_idle : assert property (@(posedge clk) disable iff (!rst_n)
        !valid |-> (grant == '0));
    a_out_range : assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, out} < (W + 1)'(N)));

endmodule
